multi_lifo: RTL and testbench
=============================

# multi_lifo

Parametrised multi-channel LIFO: NUM_CH independent stacks of DEPTH entries each, one write port and one read port, each steered by a channel index. Generalises the single-channel lifo with per-channel occupancy counts, programmable almost-full/almost-empty thresholds, a read-valid strobe and optional sticky error flags. Sits as a context/return-address store shared by several requesters in one clock domain.

## Interface
- NUM_CH, 4, number of independent stacks (≥1)
- DEPTH, 12, entries per stack (≥2)
- DATA_WIDTH, 8, entry width
- AF_TH, DEPTH-2, almost_full asserted when count ≥ AF_TH
- AE_TH, 2, almost_empty asserted when count ≤ AE_TH
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- wr_en  in  1  push request
- wr_ch  in  CH_W  push channel index
- data_wr  in  DATA_WIDTH  push data
- rd_en  in  1  pop request
- rd_ch  in  CH_W  pop channel index
- data_rd  out  DATA_WIDTH  popped data, registered
- rd_valid  out  1  data_rd updated this cycle by a successful pop/bypass
- lifo_full  out  NUM_CH  per-channel count == DEPTH
- lifo_empty  out  NUM_CH  per-channel count == 0
- almost_full  out  NUM_CH  per-channel threshold flag
- almost_empty  out  NUM_CH  per-channel threshold flag
- count  out  NUM_CH*CNT_W  per-channel occupancy, channel c at [c*CNT_W +: CNT_W]
- err_clr  in  1  clears sticky error flags
- overflow  out  NUM_CH  sticky: push to full channel
- underflow  out  NUM_CH  sticky: pop from empty channel
- CH_W = max(1,$clog2(NUM_CH)); CNT_W = $clog2(DEPTH+1)

## Operation
- Per channel: registered count sp; storage mem[c][0..DEPTH-1]; top of stack is mem[c][sp-1].
- Push (wr_en, channel not full, no same-channel pop): mem[wr_ch][sp] <= data_wr; sp+1.
- Push to full channel: dropped, sp and memory unchanged, overflow[wr_ch] set.
- Pop (rd_en, channel not empty, no same-channel push): data_rd <= mem[rd_ch][sp-1]; sp-1; rd_valid=1 next cycle.
- Pop from empty channel: data_rd holds, rd_valid=0, underflow[rd_ch] set.
- Same-channel push+pop (wr_ch==rd_ch): bypass, data_rd <= data_wr, rd_valid=1, sp and memory unchanged; valid regardless of full/empty state, no error flagged.
- Different-channel push+pop: both proceed independently in the same cycle.
- Channel index ≥ NUM_CH: operation ignored, no flag, no state change.
- Flags/count are combinational decodes of registered sp; never depend on current-cycle requests.
- err_clr has priority over a same-cycle set: flags cleared.
- Memory is not reset; contents above sp are don't-care.

## Timing
- Reset (rst=0 at rising edge): all sp=0, data_rd=0, rd_valid=0, lifo_empty all 1, lifo_full 0, almost_empty all 1, almost_full 0 (unless AF_TH=0), overflow/underflow 0. Reset mid-operation discards all stacked data; requests in reset cycles ignored.
- Push latency: count/flags reflect push one cycle after the accepting edge.
- Pop latency: data_rd and rd_valid valid one cycle after the edge sampling rd_en; rd_valid is a single-cycle pulse per accepted pop.
- Back-to-back pops on one channel return successive entries every cycle, no bubbles.

## Configuration
- MULTI_LIFO_ERR_FLAG_EN defined: overflow/underflow sticky logic and err_clr built.
- Undefined: ports remain, overflow/underflow tied 0, err_clr ignored; all other behaviour identical.

## Structure
- multi_lifo_pkg: CH_W/CNT_W helper functions, count slice helper, default threshold constants.
- Sub-module lifo_bank: one channel's memory, sp counter, full/empty/threshold decode; multi_lifo generates NUM_CH instances, steers requests, muxes data_rd, handles bypass and errors.

## Test plan (NUM_CH=4, DEPTH=12, DATA_WIDTH=8, error flags enabled)
- Push 0x11,0x22,0x33 to ch1, pop ch1 ×3 -> data_rd 0x33,0x22,0x11 with rd_valid each cycle; count[1] 3→0; lifo_empty[1]=1.
- Push 13 values to ch2 -> 13th dropped, lifo_full[2]=1, overflow[2]=1, count[2]=12; err_clr -> overflow[2]=0.
- Pop empty ch3 -> rd_valid=0, data_rd unchanged, underflow[3]=1; other channels unaffected.
- Same-cycle push 0xA5 / pop on ch0 while ch0 empty, then full -> data_rd=0xA5, rd_valid=1, count[0] unchanged, no error.
- Push ch0 0x5A while popping ch1 (top 0x77) -> data_rd=0x77, count[0]+1, count[1]-1; almost_full/almost_empty track at counts 10 and 2.
- Push 5 to ch1, assert rst=0 one cycle -> all counts 0, all empty, data_rd=0, rd_valid=0, flags cleared.

Source files
------------

// File: rtl/multi_lifo_pkg.sv
// Shared sizing helpers and default thresholds for the multi-channel LIFO.
package multi_lifo_pkg;

  localparam int unsigned AE_TH_DEFAULT     = 2;
  localparam int unsigned AF_MARGIN_DEFAULT = 2;

  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // LSB of channel ch's field in a packed per-channel count vector
  function automatic int unsigned cnt_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/lifo_bank.sv
// One LIFO channel: storage, stack pointer and occupancy/threshold decode.
module lifo_bank
  import multi_lifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_TH      = 10,
  parameter int unsigned AE_TH      = 2,
  localparam int unsigned CNT_W     = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_wr,
  output logic [DATA_WIDTH-1:0] top_c,
  output logic [CNT_W-1:0]      count,
  output logic                  full_c,
  output logic                  empty_c,
  output logic                  almost_full_c,
  output logic                  almost_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      sp_m1;

  assign sp_m1 = count - CNT_W'(1);

  // Push and pop arrive pre-qualified and mutually exclusive
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (push) begin
      count <= count + CNT_W'(1);
    end else if (pop) begin
      count <= sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[AW'(count)] <= data_wr;
    end
  end

  assign top_c          = mem[AW'(sp_m1)];
  assign full_c         = (count == CNT_W'(DEPTH));
  assign empty_c        = (count == '0);
  assign almost_full_c  = (count >= CNT_W'(AF_TH));
  assign almost_empty_c = (count <= CNT_W'(AE_TH));

endmodule

// File: rtl/multi_lifo.sv
// NUM_CH independent LIFOs sharing one push and one pop port, with same-channel bypass.
// Optional sticky overflow/underflow flags built when MULTI_LIFO_ERR_FLAG_EN is defined.
module multi_lifo
  import multi_lifo_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH      = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_TH      = DEPTH - AF_MARGIN_DEFAULT,
  parameter int unsigned AE_TH      = AE_TH_DEFAULT,
  localparam int unsigned CH_W      = ch_w(NUM_CH),
  localparam int unsigned CNT_W     = cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [DATA_WIDTH-1:0]   data_wr,
  input  logic                    rd_en,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [DATA_WIDTH-1:0]   data_rd,
  output logic                    rd_valid,
  output logic [NUM_CH-1:0]       lifo_full,
  output logic [NUM_CH-1:0]       lifo_empty,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       almost_empty,
  output logic [NUM_CH*CNT_W-1:0] count,
  input  logic                    err_clr,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       underflow
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  bypass;
  logic [NUM_CH-1:0]     wr_sel;
  logic [NUM_CH-1:0]     rd_sel;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [DATA_WIDTH-1:0] top_c [NUM_CH];
  logic [DATA_WIDTH-1:0] rd_top_c;

  // Out-of-range channel indices are silently ignored
  assign wr_ok  = wr_en && ({1'b0, wr_ch} < NUM_CH_V);
  assign rd_ok  = rd_en && ({1'b0, rd_ch} < NUM_CH_V);
  assign bypass = wr_ok && rd_ok && (wr_ch == rd_ch);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_sel[c] = wr_ok && !bypass && (wr_ch == CH_W'(c));
    assign rd_sel[c] = rd_ok && !bypass && (rd_ch == CH_W'(c));
    assign push[c]   = wr_sel[c] && !lifo_full[c];
    assign pop[c]    = rd_sel[c] && !lifo_empty[c];

    lifo_bank #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .AF_TH      (AF_TH),
      .AE_TH      (AE_TH)
    ) u_bank (
      .clk            (clk),
      .rst            (rst),
      .push           (push[c]),
      .pop            (pop[c]),
      .data_wr        (data_wr),
      .top_c          (top_c[c]),
      .count          (count[cnt_lsb(c, CNT_W) +: CNT_W]),
      .full_c         (lifo_full[c]),
      .empty_c        (lifo_empty[c]),
      .almost_full_c  (almost_full[c]),
      .almost_empty_c (almost_empty[c])
    );
  end

  always_comb begin
    rd_top_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        rd_top_c = top_c[c];
      end
    end
  end

  // data_rd holds across failed pops; rd_valid pulses once per delivered entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_rd  <= '0;
      rd_valid <= 1'b0;
    end else if (bypass) begin
      data_rd  <= data_wr;
      rd_valid <= 1'b1;
    end else if (|pop) begin
      data_rd  <= rd_top_c;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

`ifdef MULTI_LIFO_ERR_FLAG_EN
  logic [NUM_CH-1:0] ovf_set;
  logic [NUM_CH-1:0] unf_set;

  assign ovf_set = wr_sel & lifo_full;
  assign unf_set = rd_sel & lifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow  <= '0;
      underflow <= '0;
    end else if (err_clr) begin
      overflow  <= '0;
      underflow <= '0;
    end else begin
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign overflow       = '0;
  assign underflow      = '0;
`endif

endmodule

// File: tb/tb_multi_lifo.sv
// Scoreboard bench for multi_lifo: a stack model predicts pops, counts and flags each cycle.
module tb_multi_lifo;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 12;
  localparam int CNT_W  = 4;
  localparam int AF_TH  = 10;
  localparam int AE_TH  = 2;
`ifdef MULTI_LIFO_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wr_en;
  logic [1:0]              wr_ch;
  logic [7:0]              data_wr;
  logic                    rd_en;
  logic [1:0]              rd_ch;
  logic [7:0]              data_rd;
  logic                    rd_valid;
  logic [NUM_CH-1:0]       lifo_full;
  logic [NUM_CH-1:0]       lifo_empty;
  logic [NUM_CH-1:0]       almost_full;
  logic [NUM_CH-1:0]       almost_empty;
  logic [NUM_CH*CNT_W-1:0] count;
  logic                    err_clr;
  logic [NUM_CH-1:0]       overflow;
  logic [NUM_CH-1:0]       underflow;

  multi_lifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .data_wr      (data_wr),
    .rd_en        (rd_en),
    .rd_ch        (rd_ch),
    .data_rd      (data_rd),
    .rd_valid     (rd_valid),
    .lifo_full    (lifo_full),
    .lifo_empty   (lifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_stk [NUM_CH][DEPTH];
  int         m_sp  [NUM_CH];
  logic [3:0] m_ovf;
  logic [3:0] m_unf;
  logic [7:0] exp_q [$];
  logic [7:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit exp_rv);
    logic [15:0] e_cnt;
    logic [3:0]  e_full, e_empty, e_af, e_ae;
    logic [7:0]  d;
    if (exp_rv) begin
      d = exp_q.pop_front();
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("data_rd", 32'(data_rd), 32'(d));
      last_rd = d;
    end else begin
      check("rd_valid_idle", 32'(rd_valid), 32'd0);
      check("data_rd_hold", 32'(data_rd), 32'(last_rd));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e_cnt[c*CNT_W +: CNT_W] = 4'(m_sp[c]);
      e_full[c]  = (m_sp[c] == DEPTH);
      e_empty[c] = (m_sp[c] == 0);
      e_af[c]    = (m_sp[c] >= AF_TH);
      e_ae[c]    = (m_sp[c] <= AE_TH);
    end
    check("count", 32'(count), 32'(e_cnt));
    check("lifo_full", 32'(lifo_full), 32'(e_full));
    check("lifo_empty", 32'(lifo_empty), 32'(e_empty));
    check("almost_full", 32'(almost_full), 32'(e_af));
    check("almost_empty", 32'(almost_empty), 32'(e_ae));
    check("overflow", 32'(overflow), ERR_EN ? 32'(m_ovf) : 32'd0);
    check("underflow", 32'(underflow), ERR_EN ? 32'(m_unf) : 32'd0);
  endtask

  // Drive one cycle of requests, advance the model, compare after the edge
  task automatic cycle(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                       input logic re, input logic [1:0] rc, input logic ec);
    bit exp_rv = 1'b0;
    wr_en = we; wr_ch = wc; data_wr = wd;
    rd_en = re; rd_ch = rc; err_clr = ec;
    if (we && re && wc == rc) begin
      exp_q.push_back(wd);
      exp_rv = 1'b1;
    end else begin
      if (we) begin
        if (m_sp[wc] == DEPTH) m_ovf[wc] = 1'b1;
        else begin
          m_stk[wc][m_sp[wc]] = wd;
          m_sp[wc]++;
        end
      end
      if (re) begin
        if (m_sp[rc] == 0) m_unf[rc] = 1'b1;
        else begin
          m_sp[rc]--;
          exp_q.push_back(m_stk[rc][m_sp[rc]]);
          exp_rv = 1'b1;
        end
      end
    end
    if (ec) begin
      m_ovf = '0;
      m_unf = '0;
    end
    @(posedge clk);
    #1;
    check_outputs(exp_rv);
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] d);
    cycle(1'b1, c, d, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic pop(input logic [1:0] c);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, c, 1'b0);
  endtask

  // Reset cycle with live requests on the bus; they must be discarded
  task automatic do_reset();
    rst = 1'b0;
    wr_en = 1'b1; wr_ch = 2'd1; data_wr = 8'hEE;
    rd_en = 1'b1; rd_ch = 2'd2; err_clr = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) m_sp[c] = 0;
    m_ovf = '0;
    m_unf = '0;
    exp_q.delete();
    last_rd = 8'h00;
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
    check_outputs(1'b0);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_ch = '0; data_wr = '0;
    rd_en = 1'b0; rd_ch = '0; err_clr = 1'b0;
    do_reset();

    // LIFO order on ch1
    push(2'd1, 8'h11); push(2'd1, 8'h22); push(2'd1, 8'h33);
    pop(2'd1); pop(2'd1); pop(2'd1);

    // Overflow on ch2, then clear
    for (int i = 0; i < 13; i++) push(2'd2, 8'(8'h80 + i));
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);

    // Underflow on empty ch3
    pop(2'd3);

    // Same-channel bypass on ch0 while empty and while full
    cycle(1'b1, 2'd0, 8'hA5, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) push(2'd0, 8'(8'h40 + i));
    cycle(1'b1, 2'd0, 8'hA6, 1'b1, 2'd0, 1'b0);

    // Cross-channel push/pop landing on the threshold counts
    pop(2'd0); pop(2'd0); pop(2'd0);
    push(2'd1, 8'h01); push(2'd1, 8'h02); push(2'd1, 8'h77);
    cycle(1'b1, 2'd0, 8'h5A, 1'b1, 2'd1, 1'b0);
    pop(2'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 15) == 0));
    end

    // Reset mid-operation discards stacked data
    for (int i = 0; i < 5; i++) push(2'd1, 8'(8'hC0 + i));
    do_reset();
    pop(2'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
